// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the lsu_wide load/store unit.
//   lsu_state_e : FSM state encoding (3 bits)
//   clog2()     : ceiling log2 used to size the word-offset field
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RSP   = 3'd4
  } lsu_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_wide_if.sv
// lsu_wide_if: LiteDRAM native user port (command, write-data and read-data
// channels) between the load/store unit and the DRAM controller.
//   master : LSU side (drives command and write data, accepts read data)
//   slave  : DRAM controller side
// Parameters: DATA_W (line width, bits), ADDR_W (line-address width).
interface lsu_wide_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 24
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [DATA_W-1:0] rdata_data;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] wdata_data;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [BE_W-1:0]   wdata_we;

  modport master (
    output cmd_addr, cmd_valid, cmd_we, rdata_ready, wdata_data, wdata_valid, wdata_we,
    input  cmd_ready, rdata_data, rdata_valid, wdata_ready
  );

  modport slave (
    input  cmd_addr, cmd_valid, cmd_we, rdata_ready, wdata_data, wdata_valid, wdata_we,
    output cmd_ready, rdata_data, rdata_valid, wdata_ready
  );

endinterface

// File: rtl/lsu_line_buf.sv
// lsu_line_buf: single-line read buffer {valid, tag, line} for lsu_wide.
// Only instantiated when LSU_LINE_BUF_EN is defined.
//   clk_i, rst_i          : clock, synchronous active-high reset (clears valid)
//   flush_i               : invalidate the line (takes effect next cycle)
//   lookup_tag_i          : line address of the incoming request
//   hit_o, line_o         : hit indication (suppressed by flush_i) and buffered line
//   fill_en_i/tag/line    : load-miss fill on the DRAM read handshake
//   wr_en_i/tag/line/be   : write-through store; merged only on a tag hit
module lsu_line_buf #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [ADDR_W-1:0]   lookup_tag_i,
  output logic                hit_o,
  output logic [DATA_W-1:0]   line_o,
  input  logic                fill_en_i,
  input  logic [ADDR_W-1:0]   fill_tag_i,
  input  logic [DATA_W-1:0]   fill_line_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]   wr_line_i,
  input  logic [DATA_W/8-1:0] wr_be_i
);
  localparam int BE_W = DATA_W / 8;

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] line_q;
  logic              wr_hit;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_line,
                                                    input logic [DATA_W-1:0] new_line,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_line;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_line[8*b +: 8];
    end
    return r;
  endfunction

  // A flush in the lookup cycle forces a miss so the load goes to DRAM.
  assign hit_o  = valid_q && (tag_q == lookup_tag_i) && !flush_i;
  assign line_o = line_q;
  assign wr_hit = wr_en_i && valid_q && (tag_q == wr_tag_i);

  // Flush has priority so a fill racing a flush leaves the buffer invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fill_en_i) begin
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q  <= fill_tag_i;
      line_q <= fill_line_i;
    end else if (wr_hit) begin
      line_q <= merge_bytes(line_q, wr_line_i, wr_be_i);
    end
  end

endmodule

// File: rtl/lsu_wide.sv
// lsu_wide: load/store unit bridging a 32-bit CPU data port to a LiteDRAM
// native port of DATA_W bits. One access in flight; FSM
// IDLE -> CMD -> (WRITE | READ) -> RSP -> IDLE.
// Optional macro LSU_LINE_BUF_EN adds a one-line read buffer (lsu_line_buf):
// load hits go IDLE -> RSP without DRAM traffic, stores write through.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  : CPU request handshake
//   cmd_addr_i, cmd_data_i   : byte address ([1:0] ignored), store data
//   cmd_we_i, cmd_wdata_we_i : 1=store, store byte enables
//   flush_i                  : invalidate line buffer (unused without macro)
//   litedram                 : LiteDRAM native port (lsu_wide_if.master)
//   rsp_valid_o/rsp_ready_i  : response handshake, loads and stores
//   rsp_data_o               : load data, 0 for stores
module lsu_wide
  import lsu_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [31:0]       cmd_addr_i,
  input  logic [31:0]       cmd_data_i,
  input  logic              cmd_we_i,
  input  logic [3:0]        cmd_wdata_we_i,
  input  logic              flush_i,
  lsu_wide_if.master        litedram,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o
);
  localparam int WORDS = DATA_W / 32;
  localparam int OFS_W = clog2(WORDS);
  localparam int BE_W  = DATA_W / 8;

  lsu_state_e state_q, state_n;

  // Registered outputs
  logic              cmd_ready_q;
  logic              dcmd_valid_q;
  logic              dcmd_we_q;
  logic [ADDR_W-1:0] dcmd_addr_q;
  logic              wdata_valid_q;
  logic [DATA_W-1:0] wdata_data_q;
  logic [BE_W-1:0]   wdata_we_q;
  logic              rdata_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;

  // Request latched at accept
  logic              we_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic [OFS_W-1:0]  off_q;

  logic [ADDR_W-1:0] req_line;
  logic [OFS_W-1:0]  req_off;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_line;

  logic accept, hit_accept, cmd_hs, wdata_hs, rdata_hs, rsp_hs;

  function automatic logic [DATA_W-1:0] steer_data(input logic [31:0] d,
                                                   input logic [OFS_W-1:0] off);
    logic [DATA_W-1:0] r;
    r = '0;
    r[32*off +: 32] = d;
    return r;
  endfunction

  function automatic logic [BE_W-1:0] steer_be(input logic [3:0] be,
                                               input logic [OFS_W-1:0] off);
    logic [BE_W-1:0] r;
    r = '0;
    r[4*off +: 4] = be;
    return r;
  endfunction

  function automatic logic [31:0] pick_word(input logic [DATA_W-1:0] line,
                                            input logic [OFS_W-1:0] off);
    return line[32*off +: 32];
  endfunction

  assign req_line = cmd_addr_i[OFS_W+2 +: ADDR_W];
  assign req_off  = cmd_addr_i[2 +: OFS_W];

  // Address bits outside the line/offset fields are intentionally dropped.
  logic [31:0] unused_addr;
  assign unused_addr = cmd_addr_i;

`ifdef LSU_LINE_BUF_EN
  lsu_line_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .lookup_tag_i (req_line),
    .hit_o        (buf_hit),
    .line_o       (buf_line),
    .fill_en_i    (rdata_hs),
    .fill_tag_i   (dcmd_addr_q),
    .fill_line_i  (litedram.rdata_data),
    .wr_en_i      (wdata_hs),
    .wr_tag_i     (dcmd_addr_q),
    .wr_line_i    (wdata_data_q),
    .wr_be_i      (wdata_we_q)
  );
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign buf_hit      = 1'b0;
  assign buf_line     = '0;
`endif

  always_comb begin
    state_n    = state_q;
    accept     = 1'b0;
    hit_accept = 1'b0;
    cmd_hs     = 1'b0;
    wdata_hs   = 1'b0;
    rdata_hs   = 1'b0;
    rsp_hs     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gate on the registered ready so nothing is taken while it is still low after reset.
        if (cmd_valid_i && cmd_ready_q) begin
          accept = 1'b1;
          if (!cmd_we_i && buf_hit) begin
            hit_accept = 1'b1;
            state_n    = ST_RSP;
          end else begin
            state_n = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (litedram.cmd_ready) begin
          cmd_hs  = 1'b1;
          state_n = we_q ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (litedram.wdata_ready) begin
          wdata_hs = 1'b1;
          state_n  = ST_RSP;
        end
      end
      ST_READ: begin
        if (litedram.rdata_valid) begin
          rdata_hs = 1'b1;
          state_n  = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_hs  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs; valids/readies track the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      dcmd_valid_q  <= 1'b0;
      dcmd_we_q     <= 1'b0;
      dcmd_addr_q   <= '0;
      wdata_valid_q <= 1'b0;
      wdata_data_q  <= '0;
      wdata_we_q    <= '0;
      rdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_n;
      cmd_ready_q   <= (state_n == ST_IDLE);
      dcmd_valid_q  <= (state_n == ST_CMD);
      wdata_valid_q <= (state_n == ST_WRITE);
      rdata_ready_q <= (state_n == ST_READ);
      rsp_valid_q   <= (state_n == ST_RSP);
      if (accept) begin
        dcmd_addr_q <= req_line;
        dcmd_we_q   <= cmd_we_i;
      end
      if (cmd_hs && we_q) begin
        wdata_data_q <= steer_data(data_q, off_q);
        wdata_we_q   <= steer_be(be_q, off_q);
      end
      if (wdata_hs) begin
        wdata_data_q <= '0;
        wdata_we_q   <= '0;
      end
      if (rdata_hs)   rsp_data_q <= pick_word(litedram.rdata_data, off_q);
      if (hit_accept) rsp_data_q <= pick_word(buf_line, req_off);
      if (rsp_hs)     rsp_data_q <= '0;
    end
  end

  // Request payload, captured on accept only
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q   <= cmd_we_i;
      data_q <= cmd_data_i;
      be_q   <= cmd_wdata_we_i;
      off_q  <= req_off;
    end
  end

  assign cmd_ready_o          = cmd_ready_q;
  assign litedram.cmd_addr    = dcmd_addr_q;
  assign litedram.cmd_valid   = dcmd_valid_q;
  assign litedram.cmd_we      = dcmd_we_q;
  assign litedram.rdata_ready = rdata_ready_q;
  assign litedram.wdata_data  = wdata_data_q;
  assign litedram.wdata_valid = wdata_valid_q;
  assign litedram.wdata_we    = wdata_we_q;
  assign rsp_valid_o          = rsp_valid_q;
  assign rsp_data_o           = rsp_data_q;

endmodule
